sram_arbiter: RTL



---
 rtl/sram_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares the external 2 x 512Kx8 SRAM pair (1 MB, chip chosen by addr[19])
//   between port A (CPU/chipset bus) and port B (video/DMA fetch).
//   Each access is a fixed-length registered cycle:
//     IDLE -> ACC (WAIT_STATES+1 cycles) -> END (ack pulse) -> IDLE
//   so req-to-ack latency is WAIT_STATES+2 and peak throughput is one access
//   per WAIT_STATES+3 cycles. Every SRAM-side output and every ack comes
//   straight from a flop; no req reaches an output combinationally.
//
// Parameters
//   WAIT_STATES     extra access cycles beyond the first (0..7)
//
// Build option
//   SRAM_ARB_VIDEO_PRIORITY_EN  defined: port B wins every simultaneous
//                               request. Undefined: round-robin on last grant.
//
// Ports
//   clk_chipset, reset_n        clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A level request, held until a_ack
//   a_ack, a_rdata              one-cycle done pulse, read data (held)
//   b_*                         same roles for port B
//   sram_addr, sram_dq_o        shared address / write data to both chips
//   sram1_we_n, sram1_dq_oe     chip 1 (addr[19]=0) strobe and drive enable
//   sram2_we_n, sram2_dq_oe     chip 2 (addr[19]=1) strobe and drive enable
//   sram1_dq_i, sram2_dq_i      chip data buses (input side)
module sram_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_chipset,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [19:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [19:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [18:0] sram_addr,
  output logic        sram1_we_n,
  output logic        sram2_we_n,
  output logic [7:0]  sram_dq_o,
  output logic        sram1_dq_oe,
  output logic        sram2_dq_oe,
  input  logic [7:0]  sram1_dq_i,
  input  logic [7:0]  sram2_dq_i
);

  localparam logic [2:0] CNT_LAST = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_END} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic        gnt_b_q;   // port served by the access in flight
  logic        we_q;
  logic        sel_q;     // latched addr[19]: 0 = chip 1, 1 = chip 2
  logic        any_req, cnt_done, pick_b;
  logic        m_we;
  logic [19:0] m_addr;
  logic [7:0]  m_wdata;

  assign any_req  = a_req | b_req;
  assign cnt_done = (cnt_q == CNT_LAST);

`ifdef SRAM_ARB_VIDEO_PRIORITY_EN
  assign pick_b = b_req;
`else
  // last_b_q resets to 1 so that A wins the very first tie.
  logic last_b_q;
  assign pick_b = b_req & (~a_req | ~last_b_q);

  always_ff @(posedge clk_chipset) begin
    if (!reset_n)                          last_b_q <= 1'b1;
    else if (state_q == S_IDLE && any_req) last_b_q <= pick_b;
  end
`endif

  // Request fields of whichever port wins this IDLE cycle.
  always_comb begin
    m_we    = a_we;
    m_addr  = a_addr;
    m_wdata = a_wdata;
    if (pick_b) begin
      m_we    = b_we;
      m_addr  = b_addr;
      m_wdata = b_wdata;
    end
  end

  always_ff @(posedge clk_chipset) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req)  state_d = S_ACC;
      S_ACC:   if (cnt_done) state_d = S_END;
      S_END:                 state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_chipset) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      gnt_b_q     <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 1'b0;
      sram_addr   <= '0;
      sram_dq_o   <= '0;
      sram1_we_n  <= 1'b1;
      sram2_we_n  <= 1'b1;
      sram1_dq_oe <= 1'b0;
      sram2_dq_oe <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state_q)
        S_IDLE: if (any_req) begin
          // Address, data and strobe all launch on this edge, so the
          // address is set up no later than we_n falls.
          gnt_b_q     <= pick_b;
          we_q        <= m_we;
          sel_q       <= m_addr[19];
          cnt_q       <= '0;
          sram_addr   <= m_addr[18:0];
          sram_dq_o   <= m_wdata;
          sram1_we_n  <= ~(m_we & ~m_addr[19]);
          sram2_we_n  <= ~(m_we &  m_addr[19]);
          sram1_dq_oe <= m_we & ~m_addr[19];
          sram2_dq_oe <= m_we &  m_addr[19];
        end
        S_ACC: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_done) begin
            // Strobe rises here; addr/data/oe stay put through END for hold.
            sram1_we_n <= 1'b1;
            sram2_we_n <= 1'b1;
            a_ack      <= ~gnt_b_q;
            b_ack      <=  gnt_b_q;
            if (!we_q) begin
              if (gnt_b_q) b_rdata <= sel_q ? sram2_dq_i : sram1_dq_i;
              else         a_rdata <= sel_q ? sram2_dq_i : sram1_dq_i;
            end
          end
        end
        S_END: begin
          sram1_dq_oe <= 1'b0;
          sram2_dq_oe <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
